// File: rtl/sevenseg_capture.sv
// sevenseg_capture: receive side of a multiplexed seven-segment bus.
// Qualifies each digit once {an, seg} has held steady for STABLE_CYCLES
// cycles, decodes the glyph back to hex and assembles NDIG digits into a
// frame that is presented on a valid/ready output.
// Optional build macro: SEVENSEG_DP_EN (capture seg[7] per slot onto out_dp).
//
// state   | meaning
// COLLECT | filling slots, no frame presented
// HOLD    | out_valid=1, frame waiting for out_ready; slots keep filling
module sevenseg_capture #(
   parameter int NDIG          = 4,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NDIG-1:0]     an,
   input  logic [7:0]          seg,
   output logic [4*NDIG-1:0]   out_value,
   output logic [NDIG-1:0]     out_err,
   output logic [NDIG-1:0]     out_dp,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                overrun
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

   localparam logic ST_COLLECT = 1'b0;
   localparam logic ST_HOLD    = 1'b1;

   logic                  state;
   logic [NDIG+7:0]       prev;
   logic [CW-1:0]         cnt;
   logic [CW-1:0]         cnt_next;
   logic                  captured;
   logic                  one_hot;
   logic                  changed;
   logic                  do_cap;
   logic [7:0]            seg_m;
   logic [3:0]            dec_val;
   logic                  dec_err;
   logic [4*NDIG-1:0]     slot_val;
   logic [NDIG-1:0]       slot_err;
   logic [NDIG-1:0]       filled;
   logic [NDIG-1:0]       filled_next;
   logic                  frame_done;

`ifdef SEVENSEG_DP_EN
   logic [NDIG-1:0]       slot_dp;
   assign seg_m = seg;
`else
   // dp is ignored entirely so that toggling it never breaks a dwell
   assign seg_m = seg & 8'h7f;
`endif

   // dwell tracking: a change or a non one-hot anode restarts the count
   always_comb begin
      one_hot  = $onehot(an);
      changed  = ({an, seg_m} != prev) || !one_hot;
      cnt_next = cnt;
      if (changed)
         cnt_next = CW'(1);
      else if (cnt != CNT_MAX)
         cnt_next = cnt + 1'b1;
      do_cap = one_hot && (cnt_next == CNT_MAX) && (changed || !captured);
   end

   // glyph decode; anything unrecognised reads as 0 with err set
   always_comb begin
      dec_val = 4'h0;
      dec_err = 1'b0;
      case (seg[6:0])
         7'h3f: dec_val = 4'h0;
         7'h06: dec_val = 4'h1;
         7'h5b: dec_val = 4'h2;
         7'h4f: dec_val = 4'h3;
         7'h66: dec_val = 4'h4;
         7'h6d: dec_val = 4'h5;
         7'h7d: dec_val = 4'h6;
         7'h07: dec_val = 4'h7;
         7'h7f: dec_val = 4'h8;
         7'h6f: dec_val = 4'h9;
         7'h77: dec_val = 4'ha;
         7'h7c: dec_val = 4'hb;
         7'h39: dec_val = 4'hc;
         7'h5e: dec_val = 4'hd;
         7'h79: dec_val = 4'he;
         7'h71: dec_val = 4'hf;
         default: dec_err = 1'b1;
      endcase
   end

   // a completed frame always empties the mask; a capture on that same edge
   // belongs to the next frame and survives
   always_comb begin
      frame_done  = &filled;
      filled_next = frame_done ? '0 : filled;
      if (do_cap)
         filled_next = filled_next | an;
   end

   // input history, stability counter and slot storage
   always_ff @(posedge clk) begin
      if (!reset) begin
         prev     <= '0;
         cnt      <= '0;
         captured <= 1'b0;
         slot_val <= '0;
         slot_err <= '0;
         filled   <= '0;
      end else begin
         prev     <= {an, seg_m};
         cnt      <= cnt_next;
         captured <= changed ? do_cap : (captured | do_cap);
         filled   <= filled_next;
         for (int i = 0; i < NDIG; i++) begin
            if (do_cap && an[i]) begin
               slot_val[4*i +: 4] <= dec_val;
               slot_err[i]        <= dec_err;
            end
         end
      end
   end

   // frame presentation and handshake
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= ST_COLLECT;
         out_value <= '0;
         out_err   <= '0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         case (state)
            ST_COLLECT: begin
               if (frame_done) begin
                  out_value <= slot_val;
                  out_err   <= slot_err;
                  out_valid <= 1'b1;
                  state     <= ST_HOLD;
               end
            end
            default: begin
               if (frame_done) begin
                  if (out_ready) begin
                     out_value <= slot_val;
                     out_err   <= slot_err;
                  end else begin
                     overrun   <= 1'b1;
                  end
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= ST_COLLECT;
               end
            end
         endcase
      end
   end

`ifdef SEVENSEG_DP_EN
   // per-slot dp capture and its output register follow the digit path
   always_ff @(posedge clk) begin
      if (!reset) begin
         slot_dp <= '0;
         out_dp  <= '0;
      end else begin
         for (int i = 0; i < NDIG; i++)
            if (do_cap && an[i])
               slot_dp[i] <= seg[7];
         if (frame_done && (state == ST_COLLECT || out_ready))
            out_dp <= slot_dp;
      end
   end
`else
   assign out_dp = '0;
`endif

endmodule

// File: tb/tb_sevenseg_capture.sv
// Scoreboard bench for sevenseg_capture (NDIG=4, STABLE_CYCLES=4).
// Stimulus pushes expected frames; the monitor pops on each handshake.
module tb_sevenseg_capture;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  an;
   logic [7:0]  seg;
   logic [15:0] out_value;
   logic [3:0]  out_err;
   logic [3:0]  out_dp;
   logic        out_valid;
   logic        out_ready;
   logic        overrun;

   int n_vec = 0;
   int n_bad = 0;
   logic [23:0] exp_q[$];

   sevenseg_capture #(.NDIG(4), .STABLE_CYCLES(4)) dut (
      .clk(clk), .reset(reset), .an(an), .seg(seg),
      .out_value(out_value), .out_err(out_err), .out_dp(out_dp),
      .out_valid(out_valid), .out_ready(out_ready), .overrun(overrun)
   );

   always #5 clk = ~clk;

   // monitor: every accepted frame must match the head of the scoreboard
   always @(negedge clk) begin
      if (reset && out_valid && out_ready) begin
         logic [23:0] e;
         n_vec++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL frame_unexpected value=%h err=%b dp=%b required=none",
                     out_value, out_err, out_dp);
         end else begin
            e = exp_q.pop_front();
            if ({out_dp, out_err, out_value} !== e) begin
               n_bad++;
               $display("FAIL frame value=%h err=%b dp=%b required value=%h err=%b dp=%b",
                        out_value, out_err, out_dp, e[15:0], e[19:16], e[23:20]);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic apply(input logic [3:0] a, input logic [7:0] s, input int n);
      an  = a;
      seg = s;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [15:0] v, input logic [3:0] e, input logic [3:0] d);
      exp_q.push_back({d, e, v});
   endtask

   initial begin
      // reset held for two cycles during an active scan
      reset     = 1'b0;
      out_ready = 1'b0;
      apply(4'b0001, 8'h06, 2);
      chk("rst_value", out_value, 16'h0);
      chk("rst_flags", {8'h0, out_err, out_dp}, 16'h0);
      chk("rst_valid_ovr", {14'h0, out_valid, overrun}, 16'h0);
      reset = 1'b1;

      // frame 1: 4321, valid timing and hold until ready
      push(16'h4321, 4'h0, 4'h0);
      apply(4'b0001, 8'h06, 6);
      apply(4'b0010, 8'h5b, 6);
      apply(4'b0100, 8'h4f, 6);
      apply(4'b1000, 8'h66, 4);
      chk("valid_before_rise", {15'h0, out_valid}, 16'h0);
      apply(4'b1000, 8'h66, 1);
      chk("valid_rise", {15'h0, out_valid}, 16'h1);
      apply(4'b0000, 8'h00, 4);
      chk("hold_valid", {15'h0, out_valid}, 16'h1);
      chk("hold_value", out_value, 16'h4321);
      out_ready = 1'b1;
      apply(4'b0000, 8'h00, 1);
      out_ready = 1'b0;
      chk("valid_fall", {15'h0, out_valid}, 16'h0);

      // frame 2: glitching slot 2 settles on 6
      out_ready = 1'b1;
      push(16'h4621, 4'h0, 4'h0);
      apply(4'b0001, 8'h06, 6);
      apply(4'b0010, 8'h5b, 6);
      for (int k = 0; k < 3; k++) begin
         apply(4'b0100, 8'h7f, 2);
         apply(4'b0100, 8'h6f, 2);
      end
      apply(4'b0100, 8'h7d, 4);
      apply(4'b1000, 8'h66, 6);

      // frame 3: multi-hot anode never captures, blank glyph flags err
      push(16'h4301, 4'b0010, 4'h0);
      apply(4'b0011, 8'h06, 10);
      apply(4'b0010, 8'h00, 6);
      apply(4'b0100, 8'h4f, 6);
      apply(4'b1000, 8'h66, 6);
      chk("multihot_no_capture", {15'h0, out_valid}, 16'h0);
      apply(4'b0001, 8'h06, 6);

      // frames A, B, C: overrun, held frame, coincident completion
      apply(4'b0000, 8'h00, 2);
      out_ready = 1'b0;
      push(16'hba98, 4'h0, 4'h0);
      apply(4'b0001, 8'h7f, 6);
      apply(4'b0010, 8'h6f, 6);
      apply(4'b0100, 8'h77, 6);
      apply(4'b1000, 8'h7c, 6);
      chk("ovr_clear_before", {15'h0, overrun}, 16'h0);
      apply(4'b0001, 8'h39, 6);
      apply(4'b0010, 8'h5e, 6);
      apply(4'b0100, 8'h79, 6);
      apply(4'b1000, 8'h71, 6);
      chk("overrun_set", {15'h0, overrun}, 16'h1);
      chk("held_value", out_value, 16'hba98);
      chk("held_valid", {15'h0, out_valid}, 16'h1);
      push(16'h3210, 4'h0, 4'h0);
      apply(4'b0001, 8'h3f, 6);
      apply(4'b0010, 8'h06, 6);
      apply(4'b0100, 8'h5b, 6);
      apply(4'b1000, 8'h4f, 4);
      out_ready = 1'b1;
      apply(4'b1000, 8'h4f, 1);
      out_ready = 1'b0;
      chk("coincide_valid", {15'h0, out_valid}, 16'h1);
      chk("coincide_value", out_value, 16'h3210);
      out_ready = 1'b1;
      apply(4'b0000, 8'h00, 1);
      chk("coincide_drain", {15'h0, out_valid}, 16'h0);

`ifdef SEVENSEG_DP_EN
      push(16'h4321, 4'h0, 4'b0001);
      apply(4'b0001, 8'h86, 6);
`else
      // dp toggling every cycle must not disturb the dwell
      push(16'h4321, 4'h0, 4'h0);
      for (int k = 0; k < 3; k++) begin
         apply(4'b0001, 8'h86, 1);
         apply(4'b0001, 8'h06, 1);
      end
`endif
      apply(4'b0010, 8'h5b, 6);
      apply(4'b0100, 8'h4f, 6);
      apply(4'b1000, 8'h66, 6);

      // mid-frame reset discards partial slots and clears overrun
      out_ready = 1'b0;
      apply(4'b0001, 8'h06, 6);
      apply(4'b0010, 8'h5b, 6);
      reset = 1'b0;
      apply(4'b0100, 8'h4f, 2);
      chk("midrst_value", out_value, 16'h0);
      chk("midrst_flags", {8'h0, out_err, out_dp}, 16'h0);
      chk("midrst_valid_ovr", {14'h0, out_valid, overrun}, 16'h0);
      reset = 1'b1;
      apply(4'b0100, 8'h4f, 6);
      apply(4'b1000, 8'h66, 6);
      chk("partial_discarded", {15'h0, out_valid}, 16'h0);
      out_ready = 1'b1;
      push(16'h4300, 4'h0, 4'h0);
      apply(4'b0001, 8'h3f, 6);
      apply(4'b0010, 8'h3f, 6);
      apply(4'b0000, 8'h00, 4);

      chk("scoreboard_empty", 16'(exp_q.size()), 16'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
